// File: rtl/wb_wwdg_if.sv
// wb_wwdg_if: Wishbone bus bundle between a system master and the window watchdog
interface wb_wwdg_if #(
  parameter int DAT_SIZE = 16
) ();
  logic [DAT_SIZE-1:0] dat_m2s;
  logic [31:0]         adr_m2s;
  logic                cyc_m2s;
  logic                we_m2s;
  logic                stb_m2s;
  logic [DAT_SIZE-1:0] dat_s2m;
  logic                ack_s2m;
  modport master (
    output dat_m2s, adr_m2s, cyc_m2s, we_m2s, stb_m2s,
    input  dat_s2m, ack_s2m
  );
  modport slave (
    input  dat_m2s, adr_m2s, cyc_m2s, we_m2s, stb_m2s,
    output dat_s2m, ack_s2m
  );
endinterface

// File: rtl/wb_wwdg.sv
// wb_wwdg: window watchdog with early-warning interrupt on a Wishbone slave port
// Optional debug freeze (dbg_halt input) is enabled by defining WWDG_DBG_FREEZE_EN.
module wb_wwdg #(
  parameter int          CNT_SIZE     = 7,
  parameter int          PR_SIZE      = 2,
  parameter int          PRE_DIV      = 4,
  parameter int          DAT_SIZE     = 16,
  parameter int          RST_CYCLES   = 4,
  parameter logic [31:0] BASE_ADR     = 32'h0100_0000,
  parameter logic [31:0] WWDG_CR_ADR  = BASE_ADR + 32'd0,
  parameter logic [31:0] WWDG_CFR_ADR = BASE_ADR + 32'd4,
  parameter logic [31:0] WWDG_SR_ADR  = BASE_ADR + 32'd8
) (
  input  logic          clk_m2s,
  input  logic          rst_m2s,
  wb_wwdg_if.slave      bus,
`ifdef WWDG_DBG_FREEZE_EN
  input  logic          dbg_halt,
`endif
  output logic          rst_wdg,
  output logic          ewi_irq
);
  localparam int PW = $clog2(PRE_DIV) + 2**PR_SIZE - 1;
  localparam int FW = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_SIZE-1:0] EW_VAL = {1'b1, {(CNT_SIZE-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, FIRE} state_t;
  state_t              state_q;
  logic [FW-1:0]       fire_cnt_q;
  logic                rst_wdg_q;
  logic [CNT_SIZE-1:0] t_q, t_d, w_q, w_d;
  logic [PR_SIZE-1:0]  wdgtb_q, wdgtb_d, tb_act_q, tb_act_d;
  logic [PW-1:0]       pre_q, pre_d, div_m1;
  logic                wdga_q, wdga_d, ewi_q, ewi_d, ewif_q, ewif_d, early_q, early_d;
  logic                ack_q, ack_d;
  logic [DAT_SIZE-1:0] dat_q, dat_d, rdata;
  logic                halt, req, wr, hit_cr, hit_cfr, hit_sr, run_en, tick, early, fire_done;
  logic                unused;
`ifdef WWDG_DBG_FREEZE_EN
  assign halt = dbg_halt;
`else
  assign halt = 1'b0;
`endif
  assign unused = ^bus.dat_m2s;
  assign req = bus.cyc_m2s & bus.stb_m2s & ~ack_q;
  assign wr = req & bus.we_m2s & (state_q != FIRE);
  assign hit_cr = bus.adr_m2s == WWDG_CR_ADR;
  assign hit_cfr = bus.adr_m2s == WWDG_CFR_ADR;
  assign hit_sr = bus.adr_m2s == WWDG_SR_ADR;
  assign div_m1 = (PW'(PRE_DIV) << tb_act_q) - PW'(1);
  assign run_en = wdga_q & ~halt & (state_q != FIRE);
  assign tick = run_en & (pre_q == div_m1);
  assign early = wr & hit_cr & wdga_q & (t_q > w_q);
  assign fire_done = (state_q == FIRE) & (fire_cnt_q == FW'(RST_CYCLES - 1));
  assign rst_wdg = rst_wdg_q;
  assign ewi_irq = ewif_q & ewi_q;
  assign bus.ack_s2m = ack_q;
  assign bus.dat_s2m = dat_q;
  // next-state for registers, prescaler, counter and bus response; a CR write overrides a same-clock tick
  always_comb begin
    rdata = hit_cr ? DAT_SIZE'({wdga_q, t_q}) :
            hit_cfr ? DAT_SIZE'({ewi_q, wdgtb_q, w_q}) :
            hit_sr ? DAT_SIZE'(ewif_q) : '0;
    ack_d = req;
    dat_d = (req & ~bus.we_m2s) ? rdata : '0;
    pre_d = run_en ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
    t_d = tick ? t_q - CNT_SIZE'(1) : t_q;
    wdga_d = wdga_q;
    w_d = w_q;
    wdgtb_d = wdgtb_q;
    ewi_d = ewi_q;
    if (wr & hit_cr & ~early) begin
      t_d = bus.dat_m2s[CNT_SIZE-1:0];
      wdga_d = wdga_q | bus.dat_m2s[CNT_SIZE];
    end
    if (wr & hit_cfr) {ewi_d, wdgtb_d, w_d} = bus.dat_m2s[CNT_SIZE+PR_SIZE:0];
    tb_act_d = (~wdga_q | tick) ? wdgtb_d : tb_act_q;
    early_d = early_q | early;
    ewif_d = ((t_d == EW_VAL) & (t_q != EW_VAL)) | (ewif_q & ~(wr & hit_sr & ~bus.dat_m2s[0]));
    if (fire_done) begin
      pre_d = '0;
      t_d = '1;
      wdga_d = 1'b0;
      w_d = '1;
      wdgtb_d = '0;
      tb_act_d = '0;
      ewi_d = 1'b0;
      ewif_d = 1'b0;
      early_d = 1'b0;
    end
  end
  // register state
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      pre_q <= '0;
      t_q <= '1;
      wdga_q <= 1'b0;
      w_q <= '1;
      wdgtb_q <= '0;
      tb_act_q <= '0;
      ewi_q <= 1'b0;
      ewif_q <= 1'b0;
      early_q <= 1'b0;
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      pre_q <= pre_d;
      t_q <= t_d;
      wdga_q <= wdga_d;
      w_q <= w_d;
      wdgtb_q <= wdgtb_d;
      tb_act_q <= tb_act_d;
      ewi_q <= ewi_d;
      ewif_q <= ewif_d;
      early_q <= early_d;
      ack_q <= ack_d;
      dat_q <= dat_d;
    end
  end
  // reset sequencer: arm on enable, fire on expiry or early refresh, hold rst_wdg for RST_CYCLES
  always_ff @(posedge clk_m2s) begin
    if (rst_m2s) begin
      state_q <= IDLE;
      fire_cnt_q <= '0;
      rst_wdg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (wdga_q) state_q <= RUN;
        RUN: if ((~t_q[CNT_SIZE-1] & ~halt) | early_q) begin
          state_q <= FIRE;
          fire_cnt_q <= '0;
          rst_wdg_q <= 1'b1;
        end
        FIRE: if (fire_done) begin
          state_q <= IDLE;
          rst_wdg_q <= 1'b0;
        end else fire_cnt_q <= fire_cnt_q + FW'(1);
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
